sw_poll_controller: RTL and testbench
=====================================

Name: sw_poll_controller

Overview:
- Avalon-MM read master that periodically polls the slide-switch PIO (data register at address 0) and debounces the sampled value.
- Delivers each new stable switch word, with a changed-bit mask, to the exponent accelerator datapath over a valid/ready handshake.
- Sits between the SW PIO slave and the accelerator's operand-load logic, replacing software polling.

Parameters:
- WIDTH, 10, switch word width; bits readdata[WIDTH-1:0] are used.
- POLL_DIV, 50000, clk cycles between poll starts (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_CNT, 4, consecutive identical samples required to accept a value; minimum 1.
- RD_LAT, 1, fixed read latency of the slave in cycles; minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  polling enable
- avm_address  out  2  slave address; constant 0
- avm_read  out  1  read strobe, one cycle per poll
- avm_readdata  in  32  slave read data; upper bits ignored
- out_valid  out  1  new debounced word available
- out_ready  in  1  consumer accepts the word
- out_data  out  WIDTH  debounced switch word
- out_changed  out  WIDTH  XOR of previous and new committed word
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): all outputs 0, FSM in IDLE, poll timer 0, candidate 0, stable count 0, committed 0.
- Poll timer:
  - Counts 0..POLL_DIV-1 while en=1, then wraps to 0.
  - Emits a tick at the wrap.
  - Holds its value while en=0.
- FSM states: IDLE, READ, WAIT, CMP.
  - IDLE: on tick with en=1, go to READ.
  - READ: avm_read=1 for exactly one cycle; latency counter loads RD_LAT; go to WAIT.
  - WAIT: decrement the latency counter. When it reaches 0, capture s = avm_readdata[WIDTH-1:0] in that cycle, which is RD_LAT cycles after READ; go to CMP.
  - CMP (one cycle), then return to IDLE:
    - If s != candidate: candidate <= s and stable count <= 1.
    - Otherwise: stable count increments, saturating at DEBOUNCE_CNT.
- Commit:
  - Occurs in CMP when all of these hold: stable count, including this sample, is >= DEBOUNCE_CNT; candidate != committed; and no word is pending (out_valid=0, or out_valid=1 with out_ready=1 in that cycle).
  - Effect: out_data <= candidate, out_changed <= candidate ^ committed, committed <= candidate, out_valid <= 1.
  - With DEBOUNCE_CNT=1, a single differing sample commits.
- Handshake:
  - out_valid is cleared on the cycle after out_valid and out_ready are both high, unless a commit occurs in that same cycle; then out_valid stays 1 and carries the new data.
  - out_data and out_changed are stable while out_valid=1 and out_ready=0.
  - While a word is pending, debouncing continues but a commit is deferred. It happens at the first CMP after acceptance, because stable count saturates.
  - A bounce back to the committed value before acceptance cancels the deferred commit, with no spurious word.
- en=0 mid-operation: an in-progress READ/WAIT/CMP sequence completes, then the FSM stays in IDLE. Debounce state and the pending word are retained.
- Reset mid-operation: avm_read drops immediately (async), no partial commit, out_valid=0.
- Initial condition: committed=0 after reset, so non-zero switches that stay stable produce a first word.
- A stable all-zero value after reset produces no word.

Decomposition:
- Shared package exponent_accel_pkg holds:
  - FSM state enum (IDLE, READ, WAIT, CMP);
  - SW PIO data-register address constant (2'd0);
  - default POLL_DIV and DEBOUNCE_CNT constants.
- One natural sub-module: sw_poll_timer (free-running divider with enable and tick output).
- FSM, debounce and handshake logic stay in the top module.

Test Plan (POLL_DIV=4, DEBOUNCE_CNT=3, RD_LAT=1, WIDTH=10 unless noted):
- Reset then en=1, slave returns 0x000 -> avm_read pulses every 4 cycles with avm_address=0, out_valid never rises, busy=0 between polls.
- Slave returns 0x2A5 held -> out_valid rises after the 3rd poll's CMP with out_data=0x2A5, out_changed=0x2A5; with out_ready=1 it clears one cycle later.
- Stable 0x2A5 committed, then samples 0x2A4, 0x2A5, 0x2A4, 0x2A4, 0x2A4 -> exactly one word, out_data=0x2A4, out_changed=0x001, after the 5th sample.
- out_ready=0 holding the 0x2A5 word while switches settle at 0x0F0 -> out_data stays 0x2A5. Raising out_ready -> next CMP commits 0x0F0 with out_changed=0x255.
- readdata=0xFFFF_F003 -> out_data=0x003 (upper bits ignored). RD_LAT=3 variant: sample taken 3 cycles after avm_read.
- en dropped during WAIT -> the sequence finishes CMP and no further avm_read occurs. Reset asserted during READ -> avm_read=0 and out_valid=0 immediately, and the first word after release needs 3 fresh samples.

Source files
------------

// File: rtl/exponent_accel_pkg.sv
// Shared definitions for the exponent accelerator switch-polling path.
//   poll_state_t      : poll FSM state encoding (IDLE, READ, WAIT, CMP)
//   SW_PIO_DATA_ADDR  : word address of the SW PIO data register
//   DEF_POLL_DIV      : default clk cycles between polls (1 ms at 50 MHz)
//   DEF_DEBOUNCE_CNT  : default number of identical samples to accept a value
//   cnt_width()       : bits needed to hold a counter value 0..max_val
package exponent_accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_CMP
  } poll_state_t;

  localparam logic [1:0]  SW_PIO_DATA_ADDR = 2'd0;
  localparam int unsigned DEF_POLL_DIV     = 50000;
  localparam int unsigned DEF_DEBOUNCE_CNT = 4;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_poll_timer.sv
// Free-running poll divider.
//   i_clk  : system clock
//   i_rst  : asynchronous active-high reset (count -> 0)
//   i_en   : count enable; the count holds while low
//   o_tick : high for the cycle in which the count wraps POLL_DIV-1 -> 0
module sw_poll_timer
  import exponent_accel_pkg::*;
#(
  parameter int unsigned POLL_DIV = DEF_POLL_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CW = cnt_width(POLL_DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(POLL_DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = i_en && (r_count == LAST);
  assign o_tick = w_wrap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_wrap ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/sw_poll_controller.sv
// Avalon-MM read master that polls the slide-switch PIO, debounces the
// sampled word and hands each new stable word to the accelerator.
//   clk, reset    : system clock, asynchronous active-high reset
//   en            : polling enable (a started poll always completes)
//   avm_address   : slave address, always the PIO data register
//   avm_read      : one-cycle read strobe per poll
//   avm_readdata  : slave data, bits [WIDTH-1:0] used
//   out_valid     : debounced word pending
//   out_ready     : consumer accepts the pending word
//   out_data      : debounced switch word
//   out_changed   : previous committed word XOR new committed word
//   busy          : FSM outside IDLE
module sw_poll_controller
  import exponent_accel_pkg::*;
#(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned POLL_DIV     = DEF_POLL_DIV,
  parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic [31:0]      avm_readdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_changed,
  output logic             busy
);

  localparam int unsigned SCW = cnt_width(DEBOUNCE_CNT);
  localparam int unsigned LCW = cnt_width(RD_LAT);
  localparam logic [SCW-1:0] STABLE_MAX = SCW'(DEBOUNCE_CNT);

  poll_state_t      r_state;
  logic [LCW-1:0]   r_lat;
  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] r_cand;
  logic [SCW-1:0]   r_stable;
  logic [WIDTH-1:0] r_committed;
  logic             r_avm_read;
  logic             r_busy;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_out_changed;

  logic             w_tick;
  logic [SCW-1:0]   w_stable_next;
  logic             w_commit;

  sw_poll_timer #(
    .POLL_DIV(POLL_DIV)
  ) u_timer (
    .i_clk (clk),
    .i_rst (reset),
    .i_en  (en),
    .o_tick(w_tick)
  );

  generate
    if (WIDTH < 32) begin : g_unused_rdata
      logic w_unused_rdata;
      assign w_unused_rdata = ^avm_readdata[31:WIDTH];
    end
  endgenerate

  // The sample evaluated in CMP becomes the new candidate, so the commit
  // decision uses the post-update stable count and compares the sample
  // itself against the committed word.
  always_comb begin
    w_stable_next = SCW'(1);
    if (r_sample == r_cand) begin
      w_stable_next = (r_stable >= STABLE_MAX) ? STABLE_MAX : r_stable + SCW'(1);
    end
    w_commit = (r_state == ST_CMP) &&
               (w_stable_next >= STABLE_MAX) &&
               (r_sample != r_committed) &&
               (!r_out_valid || out_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_lat         <= '0;
      r_sample      <= '0;
      r_cand        <= '0;
      r_stable      <= '0;
      r_committed   <= '0;
      r_avm_read    <= 1'b0;
      r_busy        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_changed <= '0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_commit) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= r_sample;
        r_out_changed <= r_sample ^ r_committed;
        r_committed   <= r_sample;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_tick && en) begin
            r_state    <= ST_READ;
            r_avm_read <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_READ: begin
          r_avm_read <= 1'b0;
          r_lat      <= LCW'(RD_LAT);
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // Capture on the cycle the counter steps 1 -> 0, i.e. RD_LAT
          // cycles after the strobe.
          r_lat <= r_lat - LCW'(1);
          if (r_lat == LCW'(1)) begin
            r_sample <= avm_readdata[WIDTH-1:0];
            r_state  <= ST_CMP;
          end
        end
        ST_CMP: begin
          r_cand   <= r_sample;
          r_stable <= w_stable_next;
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_avm_read <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign avm_address = SW_PIO_DATA_ADDR;
  assign avm_read    = r_avm_read;
  assign busy        = r_busy;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_changed = r_out_changed;

endmodule

// File: tb/tb_sw_poll_controller.sv
module tb_sw_poll_controller;

  localparam int unsigned W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: POLL_DIV=4, DEBOUNCE_CNT=3, RD_LAT=1
  logic         en_a, out_ready_a, avm_read_a, out_valid_a, busy_a;
  logic [1:0]   avm_address_a;
  logic [31:0]  sw_a, readdata_a;
  logic [W-1:0] out_data_a, out_changed_a;
  logic         rd_pipe_a = 1'b0;

  // Instance B: POLL_DIV=8, DEBOUNCE_CNT=1, RD_LAT=3
  logic         en_b, out_ready_b, avm_read_b, out_valid_b, busy_b;
  logic [1:0]   avm_address_b;
  logic [31:0]  sw_b, readdata_b;
  logic [W-1:0] out_data_b, out_changed_b;
  logic [2:0]   rd_pipe_b = 3'b000;

  // Slave models: data is valid only on the cycle RD_LAT after the strobe,
  // otherwise a junk word that would be committed if sampled early/late.
  always @(posedge clk) begin
    rd_pipe_a <= avm_read_a;
    rd_pipe_b <= {rd_pipe_b[1:0], avm_read_b};
  end
  assign readdata_a = rd_pipe_a    ? sw_a : 32'h0000_0155;
  assign readdata_b = rd_pipe_b[2] ? sw_b : 32'h0000_0155;

  sw_poll_controller #(.WIDTH(W), .POLL_DIV(4), .DEBOUNCE_CNT(3), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .en(en_a),
    .avm_address(avm_address_a), .avm_read(avm_read_a), .avm_readdata(readdata_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_changed(out_changed_a), .busy(busy_a)
  );

  sw_poll_controller #(.WIDTH(W), .POLL_DIV(8), .DEBOUNCE_CNT(1), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .en(en_b),
    .avm_address(avm_address_b), .avm_read(avm_read_b), .avm_readdata(readdata_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_changed(out_changed_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  logic [19:0] q_a[$];
  logic [19:0] q_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rd(input bit sel);
    return sel ? avm_read_b : avm_read_a;
  endfunction
  function automatic logic bsy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction
  function automatic logic vld(input bit sel);
    return sel ? out_valid_b : out_valid_a;
  endfunction
  function automatic logic [1:0] adr(input bit sel);
    return sel ? avm_address_b : avm_address_a;
  endfunction

  // Scoreboard: each accepted word is popped and compared.
  always @(negedge clk) begin
    if (!reset && out_valid_a && out_ready_a) begin
      if (q_a.size() == 0) chk("word_a_unexpected", {12'h0, out_data_a, out_changed_a}, 32'hFFFF_FFFF);
      else chk("word_a", {12'h0, out_data_a, out_changed_a}, {12'h0, q_a.pop_front()});
    end
    if (!reset && out_valid_b && out_ready_b) begin
      if (q_b.size() == 0) chk("word_b_unexpected", {12'h0, out_data_b, out_changed_b}, 32'hFFFF_FFFF);
      else chk("word_b", {12'h0, out_data_b, out_changed_b}, {12'h0, q_b.pop_front()});
    end
  end

  // One full poll with the switches at v; returns at the first IDLE cycle.
  task automatic do_poll(input bit sel, input logic [31:0] v, input bit push,
                         input bit exp_valid, input logic [9:0] d, input logic [9:0] c);
    int n;
    if (!sel) sw_a = v; else sw_b = v;
    if (push) begin
      if (!sel) q_a.push_back({d, c}); else q_b.push_back({d, c});
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!rd(sel) && n < 40);
    chk("poll_start", {31'h0, rd(sel)}, 32'h1);
    chk("avm_address", {30'h0, adr(sel)}, 32'h0);
    @(negedge clk);
    chk("read_one_cycle", {31'h0, rd(sel)}, 32'h0);
    n = 0;
    while (bsy(sel) && n < 40) begin @(negedge clk); n++; end
    chk("busy_idle", {31'h0, bsy(sel)}, 32'h0);
    chk("valid_after_cmp", {31'h0, vld(sel)}, {31'h0, exp_valid});
  endtask

  task automatic set_ready(input bit sel, input logic v);
    @(posedge clk);
    #1;
    if (!sel) out_ready_a = v; else out_ready_b = v;
  endtask

  typedef struct {
    logic [31:0] sw;
    bit          exp_word;
    logic [9:0]  exp_data;
    logic [9:0]  exp_changed;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0]  = '{32'h0000_0000, 1'b0, 10'h000, 10'h000};
    tbl[1]  = '{32'h0000_0000, 1'b0, 10'h000, 10'h000};
    tbl[2]  = '{32'h0000_0000, 1'b0, 10'h000, 10'h000};
    tbl[3]  = '{32'h0000_02A5, 1'b0, 10'h000, 10'h000};
    tbl[4]  = '{32'h0000_02A5, 1'b0, 10'h000, 10'h000};
    tbl[5]  = '{32'h0000_02A5, 1'b1, 10'h2A5, 10'h2A5};
    tbl[6]  = '{32'h0000_02A4, 1'b0, 10'h000, 10'h000};
    tbl[7]  = '{32'h0000_02A5, 1'b0, 10'h000, 10'h000};
    tbl[8]  = '{32'h0000_02A4, 1'b0, 10'h000, 10'h000};
    tbl[9]  = '{32'h0000_02A4, 1'b0, 10'h000, 10'h000};
    tbl[10] = '{32'h0000_02A4, 1'b1, 10'h2A4, 10'h001};
    tbl[11] = '{32'hFFFF_F003, 1'b0, 10'h000, 10'h000};
    tbl[12] = '{32'hFFFF_F003, 1'b0, 10'h000, 10'h000};
    tbl[13] = '{32'hFFFF_F003, 1'b1, 10'h003, 10'h2A7};

    reset = 1'b1;
    en_a = 1'b0; en_b = 1'b0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    sw_a = '0; sw_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_avm_read", {31'h0, avm_read_a}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid_a}, 32'h0);
    chk("rst_busy", {31'h0, busy_a}, 32'h0);
    chk("rst_out_data", {22'h0, out_data_a}, 32'h0);
    chk("rst_out_changed", {22'h0, out_changed_a}, 32'h0);
    chk("rst_avm_address", {30'h0, avm_address_a}, 32'h0);
    chk("rst_b_valid", {31'h0, out_valid_b}, 32'h0);

    reset = 1'b0;
    en_a  = 1'b1;

    // Poll period
    n = 0;
    do begin @(negedge clk); n++; end while (!avm_read_a && n < 40);
    chk("first_poll", {31'h0, avm_read_a}, 32'h1);
    n = 0;
    do begin @(negedge clk); n++; end while (!avm_read_a && n < 40);
    chk("poll_period", n, 4);

    for (int i = 0; i < 14; i++)
      do_poll(1'b0, tbl[i].sw, tbl[i].exp_word, tbl[i].exp_word, tbl[i].exp_data, tbl[i].exp_changed);

    // Deferred commit while the consumer stalls
    set_ready(1'b0, 1'b0);
    do_poll(1'b0, 32'h2A5, 1'b0, 1'b0, 10'h0, 10'h0);
    do_poll(1'b0, 32'h2A5, 1'b0, 1'b0, 10'h0, 10'h0);
    do_poll(1'b0, 32'h2A5, 1'b1, 1'b1, 10'h2A5, 10'h2A6);
    for (int i = 0; i < 3; i++) begin
      do_poll(1'b0, 32'h0F0, 1'b0, 1'b1, 10'h0, 10'h0);
      chk("stall_data_held", {22'h0, out_data_a}, 32'h2A5);
      chk("stall_changed_held", {22'h0, out_changed_a}, 32'h2A6);
    end
    set_ready(1'b0, 1'b1);
    do_poll(1'b0, 32'h0F0, 1'b1, 1'b1, 10'h0F0, 10'h255);

    // Bounce back to committed value cancels the deferred commit
    set_ready(1'b0, 1'b0);
    do_poll(1'b0, 32'h1FF, 1'b0, 1'b0, 10'h0, 10'h0);
    do_poll(1'b0, 32'h1FF, 1'b0, 1'b0, 10'h0, 10'h0);
    do_poll(1'b0, 32'h1FF, 1'b1, 1'b1, 10'h1FF, 10'h10F);
    for (int i = 0; i < 3; i++) do_poll(1'b0, 32'h0F0, 1'b0, 1'b1, 10'h0, 10'h0);
    do_poll(1'b0, 32'h1FF, 1'b0, 1'b1, 10'h0, 10'h0);
    set_ready(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) do_poll(1'b0, 32'h1FF, 1'b0, 1'b0, 10'h0, 10'h0);

    // en dropped during WAIT
    n = 0;
    do begin @(negedge clk); n++; end while (!avm_read_a && n < 40);
    chk("en_drop_read", {31'h0, avm_read_a}, 32'h1);
    @(negedge clk);
    en_a = 1'b0;
    n = 0;
    while (busy_a && n < 40) begin @(negedge clk); n++; end
    chk("en_drop_completes", {31'h0, busy_a}, 32'h0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (avm_read_a || busy_a) n++;
    end
    chk("en_drop_no_poll", n, 0);

    // Reset during READ
    en_a = 1'b1;
    set_ready(1'b0, 1'b0);
    do_poll(1'b0, 32'h0AA, 1'b0, 1'b0, 10'h0, 10'h0);
    do_poll(1'b0, 32'h0AA, 1'b0, 1'b0, 10'h0, 10'h0);
    do_poll(1'b0, 32'h0AA, 1'b0, 1'b1, 10'h0, 10'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!avm_read_a && n < 40);
    chk("pre_reset_read", {31'h0, avm_read_a}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_avm_read", {31'h0, avm_read_a}, 32'h0);
    chk("midrst_out_valid", {31'h0, out_valid_a}, 32'h0);
    chk("midrst_busy", {31'h0, busy_a}, 32'h0);
    chk("midrst_out_data", {22'h0, out_data_a}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    set_ready(1'b0, 1'b1);
    do_poll(1'b0, 32'h0AA, 1'b0, 1'b0, 10'h0, 10'h0);
    do_poll(1'b0, 32'h0AA, 1'b0, 1'b0, 10'h0, 10'h0);
    do_poll(1'b0, 32'h0AA, 1'b1, 1'b1, 10'h0AA, 10'h0AA);
    en_a = 1'b0;

    // Instance B: single-sample commit with three-cycle read latency
    en_b = 1'b1;
    do_poll(1'b1, 32'hFFFF_F003, 1'b1, 1'b1, 10'h003, 10'h003);
    do_poll(1'b1, 32'h0000_01F0, 1'b1, 1'b1, 10'h1F0, 10'h1F3);
    do_poll(1'b1, 32'h0000_01F0, 1'b0, 1'b0, 10'h0, 10'h0);
    en_b = 1'b0;

    repeat (5) @(negedge clk);
    chk("scoreboard_a_drained", q_a.size(), 0);
    chk("scoreboard_b_drained", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
